// File: rtl/tensor_core_matmul_if.sv
// Host <-> tensor-core bundle: register-file write strobe, operand matrices,
// result matrix and the completion pulse that the host uses as its write-back enable.
interface tensor_core_matmul_if #(
  parameter int DATA_WIDTH = 4,
  parameter int DIM        = 4
);
  logic                         tensor_core_register_file_write_enable;
  logic signed [DATA_WIDTH-1:0] tensor_core_input1 [DIM][DIM];
  logic signed [DATA_WIDTH-1:0] tensor_core_input2 [DIM][DIM];
  logic signed [DATA_WIDTH-1:0] tensor_core_output [DIM][DIM];
  logic                         is_done_with_calculation;

  modport master (
    output tensor_core_register_file_write_enable,
    output tensor_core_input1,
    output tensor_core_input2,
    input  tensor_core_output,
    input  is_done_with_calculation
  );

  modport slave (
    input  tensor_core_register_file_write_enable,
    input  tensor_core_input1,
    input  tensor_core_input2,
    output tensor_core_output,
    output is_done_with_calculation
  );
endinterface

// File: rtl/tensor_core_matmul.sv
// Signed DIM x DIM matrix multiply: one k-slice of outer products per cycle,
// result written (wrap-truncated) with a one-cycle done pulse after DIM cycles.
module tensor_core_matmul #(
  parameter int DATA_WIDTH = 4,
  parameter int DIM        = 4
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  tensor_core_matmul_if.slave   bus
);
  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int ACC_W  = PROD_W + $clog2(DIM);
  localparam int K_W    = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(DIM - 1);

  typedef enum logic {IDLE, COMPUTE} state_t;

  state_t                       state_reg, state_next;
  logic [K_W-1:0]               k_reg, k_next;
  logic signed [ACC_W-1:0]      acc_reg [DIM][DIM];
  logic signed [ACC_W-1:0]      acc_next [DIM][DIM];
  logic signed [ACC_W-1:0]      sum_w [DIM][DIM];
  logic signed [DATA_WIDTH-1:0] out_reg [DIM][DIM];
  logic signed [DATA_WIDTH-1:0] out_next [DIM][DIM];
  logic                         done_reg, done_next;

  // Operands are read live each cycle; the host holds them stable while computing.
  for (genvar gi = 0; gi < DIM; gi++) begin : g_row
    for (genvar gj = 0; gj < DIM; gj++) begin : g_col
      logic signed [PROD_W-1:0] prod;
      assign prod = bus.tensor_core_input1[gi][k_reg] * bus.tensor_core_input2[k_reg][gj];
      assign sum_w[gi][gj] = acc_reg[gi][gj] + ACC_W'(prod);
      assign bus.tensor_core_output[gi][gj] = out_reg[gi][gj];
    end
  end

  assign bus.is_done_with_calculation = done_reg;

  always_ff @(posedge clock_in) begin
    if (!reset_in) begin
      state_reg <= IDLE;
      k_reg     <= '0;
      done_reg  <= 1'b0;
      for (int i = 0; i < DIM; i++) begin
        for (int j = 0; j < DIM; j++) begin
          acc_reg[i][j] <= '0;
          out_reg[i][j] <= '0;
        end
      end
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
      done_reg  <= done_next;
      acc_reg   <= acc_next;
      out_reg   <= out_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    done_next  = 1'b0;
    acc_next   = acc_reg;
    out_next   = out_reg;
    case (state_reg)
      IDLE: begin
        if (bus.tensor_core_register_file_write_enable) begin
          state_next = COMPUTE;
          k_next     = '0;
          for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++)
              acc_next[i][j] = '0;
        end
      end
      COMPUTE: begin
        // A register-file write mid-flight discards the partial sums and restarts.
        if (bus.tensor_core_register_file_write_enable) begin
          k_next = '0;
          for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++)
              acc_next[i][j] = '0;
        end else begin
          acc_next = sum_w;
          if (k_reg == K_LAST) begin
            for (int i = 0; i < DIM; i++)
              for (int j = 0; j < DIM; j++)
                out_next[i][j] = sum_w[i][j][DATA_WIDTH-1:0];
            done_next  = 1'b1;
            state_next = IDLE;
            k_next     = '0;
          end else begin
            k_next = k_reg + K_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_tensor_core_matmul.sv
// Directed bench for tensor_core_matmul: hand-computed result matrices,
// done latency/pulse-width checks, abort, back-to-back and mid-compute reset.
module tb_tensor_core_matmul;
  localparam int W = 4;
  localparam int D = 4;

  typedef int imat_t [4][4];

  logic clock_in = 1'b0;
  logic reset_in = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  tensor_core_matmul_if #(.DATA_WIDTH(W), .DIM(D)) bus ();

  tensor_core_matmul #(.DATA_WIDTH(W), .DIM(D)) dut (
    .clock_in (clock_in),
    .reset_in (reset_in),
    .bus      (bus)
  );

  always #5 clock_in = ~clock_in;

  imat_t zeros    = '{default: 0};
  imat_t sevens   = '{default: 7};
  imat_t fours    = '{default: 4};
  imat_t ones     = '{default: 1};
  imat_t neg1     = '{default: -1};
  imat_t negfours = '{default: -4};
  imat_t ident    = '{'{1, 0, 0, 0}, '{0, 1, 0, 0}, '{0, 0, 1, 0}, '{0, 0, 0, 1}};
  imat_t twoi     = '{'{2, 0, 0, 0}, '{0, 2, 0, 0}, '{0, 0, 2, 0}, '{0, 0, 0, 2}};
  imat_t diff     = '{'{0, -1, -2, -3}, '{1, 0, -1, -2}, '{2, 1, 0, -1}, '{3, 2, 1, 0}};
  imat_t diff2    = '{'{0, -2, -4, -6}, '{2, 0, -2, -4}, '{4, 2, 0, -2}, '{6, 4, 2, 0}};
  imat_t summ     = '{'{0, 1, 2, 3}, '{1, 2, 3, 4}, '{2, 3, 4, 5}, '{3, 4, 5, 6}};
  imat_t summ2    = '{'{0, 2, 4, 6}, '{2, 4, 6, -8}, '{4, 6, -8, -6}, '{6, -8, -6, -4}};

  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  task automatic load(input imat_t a, input imat_t b);
    for (int i = 0; i < D; i++) begin
      for (int j = 0; j < D; j++) begin
        bus.tensor_core_input1[i][j] = W'(a[i][j]);
        bus.tensor_core_input2[i][j] = W'(b[i][j]);
      end
    end
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input imat_t e);
    for (int i = 0; i < D; i++)
      for (int j = 0; j < D; j++)
        check($sformatf("%s[%0d][%0d]", tag, i, j), int'(bus.tensor_core_output[i][j]), e[i][j]);
  endtask

  task automatic start();
    bus.tensor_core_register_file_write_enable = 1'b1;
    tick();
    bus.tensor_core_register_file_write_enable = 1'b0;
  endtask

  // Cycles from the enable edge until done is seen, bounded so a dead DUT still finishes.
  task automatic wait_done(input string tag);
    int lat;
    lat = 0;
    while (bus.is_done_with_calculation !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, 4);
    $display("txn %s done_latency=%0d", tag, lat);
  endtask

  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      tick();
      if (bus.is_done_with_calculation === 1'b1) cnt++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bus.tensor_core_register_file_write_enable = 1'b0;
    load(zeros, zeros);

    reset_in = 1'b0;
    tick();
    tick();
    check("reset_done", int'(bus.is_done_with_calculation), 0);
    check_out("reset_out", zeros);
    reset_in = 1'b1;
    count_done(10, cnt);
    check("idle_no_done", cnt, 0);
    check_out("idle_out", zeros);
    $display("txn reset_idle done_pulses=%0d", cnt);

    load(ident, diff);
    start();
    wait_done("ident_x_diff");
    check_out("ident_x_diff", diff);
    tick();
    check("ident_done_width", int'(bus.is_done_with_calculation), 0);
    count_done(8, cnt);
    check("ident_no_repeat", cnt, 0);
    check_out("ident_hold", diff);

    load(diff, twoi);
    start();
    wait_done("diff_x_2i");
    check_out("diff_x_2i", diff2);

    load(sevens, sevens);
    start();
    wait_done("sevens");
    check_out("sevens", fours);

    load(neg1, ones);
    start();
    wait_done("neg1_x_ones");
    check_out("neg1_x_ones", negfours);

    load(sevens, sevens);
    start();
    tick();
    tick();
    load(twoi, summ);
    start();
    check("abort_no_done", int'(bus.is_done_with_calculation), 0);
    check_out("abort_hold", negfours);
    wait_done("abort_restart");
    check_out("abort_restart", summ2);

    load(sevens, sevens);
    start();
    wait_done("b2b_first");
    check_out("b2b_first", fours);
    load(neg1, ones);
    start();
    check("b2b_done_falls", int'(bus.is_done_with_calculation), 0);
    check_out("b2b_first_held", fours);
    wait_done("b2b_second");
    check_out("b2b_second", negfours);

    load(ident, summ);
    start();
    tick();
    tick();
    reset_in = 1'b0;
    tick();
    check("midreset_done", int'(bus.is_done_with_calculation), 0);
    check_out("midreset_out", zeros);
    reset_in = 1'b1;
    count_done(10, cnt);
    check("midreset_no_done", cnt, 0);
    check_out("midreset_hold", zeros);
    $display("txn mid_compute_reset done_pulses=%0d", cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
